// File: rtl/rtc_disp_pkg.sv
// Shared types and codes for the RTC display formatter: view states, digit codes,
// edit field encodings and the BCD-to-digit sanitising helper.
package rtc_disp_pkg;

   typedef enum logic [1:0] {
      BLANK     = 2'd0,
      SHOW_TIME = 2'd1,
      SHOW_DATE = 2'd2
   } disp_state_t;

   typedef struct packed {
      logic [7:0] year;
      logic [7:0] mon;
      logic [7:0] day;
      logic [7:0] hour;
      logic [7:0] min;
      logic [7:0] sec;
   } rtc_rec_t;

   localparam logic [3:0] SEP_CODE   = 4'hA;
   localparam logic [3:0] BLANK_CODE = 4'hF;

   localparam logic [2:0] SEL_SEC  = 3'd0;
   localparam logic [2:0] SEL_MIN  = 3'd1;
   localparam logic [2:0] SEL_HOUR = 3'd2;
   localparam logic [2:0] SEL_DAY  = 3'd3;
   localparam logic [2:0] SEL_MON  = 3'd4;
   localparam logic [2:0] SEL_YEAR = 3'd5;

   // Out-of-range BCD nibbles must never reach the digit decoder as raw hex.
   function automatic logic [7:0] bcd_show(input logic [7:0] b);
      bcd_show[7:4] = (b[7:4] > 4'd9) ? BLANK_CODE : b[7:4];
      bcd_show[3:0] = (b[3:0] > 4'd9) ? BLANK_CODE : b[3:0];
   endfunction

endpackage

// File: rtl/rtc_blink_tick.sv
// Free-running prescalers: blink_on square wave at BLINK_HZ and a one-cycle
// tick_1hz strobe every CLK_HZ cycles.
module rtc_blink_tick #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int BLINK_HZ = 2
) (
   input  logic clk,
   input  logic rstn,
   output logic blink_on,
   output logic tick_1hz
);

   localparam int HALF = (CLK_HZ / (2 * BLINK_HZ) > 0) ? CLK_HZ / (2 * BLINK_HZ) : 1;
   localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int SW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);
   localparam logic [SW-1:0] SEC_LAST  = SW'(CLK_HZ - 1);

   logic [BW-1:0] blink_cnt;
   logic [SW-1:0] sec_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
         sec_cnt   <= '0;
      end else begin
         if (blink_cnt == HALF_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
         if (sec_cnt == SEC_LAST) sec_cnt <= '0;
         else                     sec_cnt <= sec_cnt + 1'b1;
      end
   end

   assign tick_1hz = (sec_cnt == SEC_LAST);

endmodule

// File: rtl/rtc_disp_fmt.sv
// RTC display formatter: latches BCD time/date and drives eight digit codes for the
// scan stage. Define RTC_DISP_AUTOROT_EN to enable timed auto-rotate to the date view.
module rtc_disp_fmt
   import rtc_disp_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int BLINK_HZ    = 2,
   parameter int DATE_HOLD_S = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        time_vld,
   input  logic [7:0]  sec,
   input  logic [7:0]  min,
   input  logic [7:0]  hour,
   input  logic [7:0]  day,
   input  logic [7:0]  mon,
   input  logic [7:0]  year,
   input  logic        key_mode,
   input  logic        edit_en,
   input  logic [2:0]  edit_sel,
   output logic [31:0] disp_data,
   output logic        disp_upd
);

   rtc_rec_t        rtc_q, rtc_n;
   disp_state_t     state_q, state_nxt, view;
   logic            blink_on, tick_1hz, edit_act;
   logic [7:0][3:0] digs;
   logic [7:0]      blank_mask;
   logic [31:0]     disp_nxt;

   rtc_blink_tick #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) u_blink (
      .clk      (clk),
      .rstn     (rstn),
      .blink_on (blink_on),
      .tick_1hz (tick_1hz)
   );

   assign edit_act = edit_en && (edit_sel <= SEL_YEAR);

`ifdef RTC_DISP_AUTOROT_EN
   localparam int HOLD_W = (DATE_HOLD_S > 0) ? $clog2(DATE_HOLD_S + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(DATE_HOLD_S);

   logic [HOLD_W-1:0] hold_q, hold_nxt;
   logic              sec_to_30;

   assign sec_to_30 = time_vld && !edit_en && (sec == 8'h30) && (rtc_q.sec != 8'h30);
`else
   logic unused_tick;
   assign unused_tick = tick_1hz ^ (DATE_HOLD_S != 0);
`endif

   always_comb begin
      rtc_n = rtc_q;
      if (time_vld) begin
         rtc_n.year = year;
         rtc_n.mon  = mon;
         rtc_n.day  = day;
         rtc_n.hour = hour;
         rtc_n.min  = min;
         rtc_n.sec  = sec;
      end
   end

   // state_q is the user's chosen view; edit forcing is a display overlay only,
   // so the chosen view comes back untouched when editing ends.
   always_comb begin
      state_nxt = state_q;
`ifdef RTC_DISP_AUTOROT_EN
      hold_nxt = hold_q;
      if (tick_1hz && (hold_q != '0)) begin
         hold_nxt = hold_q - 1'b1;
         if (hold_q == HOLD_W'(1)) state_nxt = SHOW_TIME;
      end
`endif
      case (state_q)
         BLANK: if (time_vld) state_nxt = SHOW_TIME;
         SHOW_TIME: begin
            if (key_mode && !edit_act) state_nxt = SHOW_DATE;
`ifdef RTC_DISP_AUTOROT_EN
            else if (sec_to_30) begin
               state_nxt = SHOW_DATE;
               hold_nxt  = HOLD_INIT;
            end
`endif
         end
         SHOW_DATE: begin
            if (key_mode && !edit_act) begin
               state_nxt = SHOW_TIME;
`ifdef RTC_DISP_AUTOROT_EN
               hold_nxt  = '0;
`endif
            end
         end
         default: state_nxt = BLANK;
      endcase
   end

   always_comb begin
      view = state_nxt;
      if (edit_act && (state_nxt != BLANK)) begin
         if (edit_sel <= SEL_HOUR) view = SHOW_TIME;
         else                      view = SHOW_DATE;
      end

      case (view)
         SHOW_TIME: digs = {bcd_show(rtc_n.hour), SEP_CODE, bcd_show(rtc_n.min),
                            SEP_CODE, bcd_show(rtc_n.sec)};
         SHOW_DATE: digs = {4'h2, 4'h0, bcd_show(rtc_n.year), bcd_show(rtc_n.mon),
                            bcd_show(rtc_n.day)};
         default:   digs = '1;
      endcase

      blank_mask = '0;
      if (edit_act && !blink_on && (view != BLANK)) begin
         case (edit_sel)
            SEL_SEC, SEL_DAY: blank_mask = 8'b0000_0011;
            SEL_MIN:          blank_mask = 8'b0001_1000;
            SEL_HOUR:         blank_mask = 8'b1100_0000;
            SEL_MON:          blank_mask = 8'b0000_1100;
            SEL_YEAR:         blank_mask = 8'b0011_0000;
            default:          blank_mask = '0;
         endcase
      end

      disp_nxt = '0;
      for (int i = 0; i < 8; i++)
         disp_nxt[i*4 +: 4] = blank_mask[i] ? BLANK_CODE : digs[i];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= BLANK;
         rtc_q     <= '0;
         disp_data <= 32'hFFFF_FFFF;
         disp_upd  <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         rtc_q     <= rtc_n;
         disp_data <= disp_nxt;
         disp_upd  <= (disp_nxt != disp_data);
      end
   end

`ifdef RTC_DISP_AUTOROT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) hold_q <= '0;
      else       hold_q <= hold_nxt;
   end
`endif

endmodule

// File: tb/tb_rtc_disp_fmt.sv
// Directed bench for rtc_disp_fmt at CLK_HZ=8, BLINK_HZ=1, DATE_HOLD_S=3; the
// auto-rotate section follows RTC_DISP_AUTOROT_EN.
module tb_rtc_disp_fmt;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        time_vld = 1'b0, key_mode = 1'b0, edit_en = 1'b0;
   logic [2:0]  edit_sel = 3'd0;
   logic [7:0]  sec = 8'h00, min = 8'h00, hour = 8'h00;
   logic [7:0]  day = 8'h00, mon = 8'h00, year = 8'h00;
   logic [31:0] disp_data;
   logic        disp_upd;

   int checks = 0;
   int errors = 0;
   int ecnt;

   rtc_disp_fmt #(.CLK_HZ(8), .BLINK_HZ(1), .DATE_HOLD_S(3)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .time_vld  (time_vld),
      .sec       (sec),
      .min       (min),
      .hour      (hour),
      .day       (day),
      .mon       (mon),
      .year      (year),
      .key_mode  (key_mode),
      .edit_en   (edit_en),
      .edit_sel  (edit_sel),
      .disp_data (disp_data),
      .disp_upd  (disp_upd)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; prescaler phases follow from this count.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) ecnt <= 0;
      else       ecnt <= ecnt + 1;
   end

   typedef struct {
      logic        tv, km;
      logic [7:0]  hr, mn, sc, dy, mo, yr;
      logic [31:0] exp_data;
      logic        exp_upd;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic tv, input logic km,
                               input logic [7:0] hr, input logic [7:0] mn, input logic [7:0] sc,
                               input logic [7:0] dy, input logic [7:0] mo, input logic [7:0] yr,
                               input logic [31:0] ed, input logic eu);
      vec_t v;
      v.tv = tv; v.km = km; v.hr = hr; v.mn = mn; v.sc = sc;
      v.dy = dy; v.mo = mo; v.yr = yr; v.exp_data = ed; v.exp_upd = eu;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic set_rtc(input logic [7:0] hr, input logic [7:0] mn, input logic [7:0] sc,
                          input logic [7:0] dy, input logic [7:0] mo, input logic [7:0] yr);
      hour = hr; min = mn; sec = sc; day = dy; mon = mo; year = yr;
   endtask

   // Called at a negedge: drive pulses for one active edge, return at the next negedge.
   task automatic pulse(input logic tv, input logic km);
      time_vld = tv;
      key_mode = km;
      @(negedge clk);
      time_vld = 1'b0;
      key_mode = 1'b0;
   endtask

   task automatic idle(input int n, input string name, input logic [31:0] exp);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check(name, disp_data, exp);
      end
   endtask

   initial begin
      logic [31:0] exp;
      int          e_edge, t_ret;

      vecs[0]  = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 32'hFFFF_FFFF, 0);
      vecs[1]  = mk(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 32'hFFFF_FFFF, 0);
      vecs[2]  = mk(1, 0, 8'h12, 8'h34, 8'h56, 8'h09, 8'h11, 8'h24, 32'h12A3_4A56, 1);
      vecs[3]  = mk(0, 0, 8'h12, 8'h34, 8'h56, 8'h09, 8'h11, 8'h24, 32'h12A3_4A56, 0);
      vecs[4]  = mk(0, 1, 8'h12, 8'h34, 8'h56, 8'h09, 8'h11, 8'h24, 32'h2024_1109, 1);
      vecs[5]  = mk(0, 1, 8'h12, 8'h34, 8'h56, 8'h09, 8'h11, 8'h24, 32'h12A3_4A56, 1);
      vecs[6]  = mk(1, 0, 8'h12, 8'h3C, 8'h56, 8'h09, 8'h11, 8'h24, 32'h12A3_FA56, 1);
      vecs[7]  = mk(1, 1, 8'h12, 8'h35, 8'h57, 8'h10, 8'h11, 8'h24, 32'h2024_1110, 1);
      vecs[8]  = mk(0, 1, 8'h12, 8'h35, 8'h57, 8'h10, 8'h11, 8'h24, 32'h12A3_5A57, 1);
      vecs[9]  = mk(1, 0, 8'h12, 8'h35, 8'h57, 8'h10, 8'h11, 8'h24, 32'h12A3_5A57, 0);
      vecs[10] = mk(1, 0, 8'hA1, 8'h35, 8'h57, 8'h10, 8'h11, 8'h24, 32'hF1A3_5A57, 1);
      vecs[11] = mk(1, 0, 8'h12, 8'h35, 8'h59, 8'h10, 8'h11, 8'h24, 32'h12A3_5A59, 1);

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data", disp_data, 32'hFFFF_FFFF);
      check("rst_upd", {31'b0, disp_upd}, 32'd0);
      rstn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         set_rtc(vecs[i].hr, vecs[i].mn, vecs[i].sc, vecs[i].dy, vecs[i].mo, vecs[i].yr);
         pulse(vecs[i].tv, vecs[i].km);
         check($sformatf("vec%0d_data", i), disp_data, vecs[i].exp_data);
         check($sformatf("vec%0d_upd", i), {31'b0, disp_upd}, {31'b0, vecs[i].exp_upd});
      end

      // Minute field blinks with a 4-cycle half period while edited
      set_rtc(8'h12, 8'h34, 8'h56, 8'h09, 8'h11, 8'h24);
      pulse(1, 0);
      check("edit_pre", disp_data, 32'h12A3_4A56);
      edit_en  = 1'b1;
      edit_sel = 3'd1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         exp = ((((ecnt - 1) / 4) % 2) == 0) ? 32'h12A3_4A56 : 32'h12AF_FA56;
         check("blink_min", disp_data, exp);
      end
      edit_en = 1'b0;
      idle(8, "edit_drop_min", 32'h12A3_4A56);

      // Editing month forces the date view and ignores key_mode
      edit_en  = 1'b1;
      edit_sel = 3'd4;
      for (int i = 0; i < 8; i++) begin
         key_mode = (i == 3);
         @(negedge clk);
         key_mode = 1'b0;
         exp = ((((ecnt - 1) / 4) % 2) == 0) ? 32'h2024_1109 : 32'h2024_FF09;
         check("blink_mon", disp_data, exp);
      end
      edit_en = 1'b0;
      idle(2, "edit_drop_mon", 32'h12A3_4A56);

`ifdef RTC_DISP_AUTOROT_EN
      // Auto-rotate: date held until the third 1 Hz tick after entry
      set_rtc(8'h12, 8'h34, 8'h30, 8'h09, 8'h11, 8'h24);
      pulse(1, 0);
      e_edge = ecnt;
      check("rot_enter", disp_data, 32'h2024_1109);
      t_ret = (e_edge / 8 + 1) * 8 + 16;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         exp = (ecnt >= t_ret) ? 32'h12A3_4A30 : 32'h2024_1109;
         check("rot_hold", disp_data, exp);
      end

      // key_mode during the hold cancels it
      sec = 8'h29;
      pulse(1, 0);
      check("rot2_pre", disp_data, 32'h12A3_4A29);
      sec = 8'h30;
      pulse(1, 0);
      check("rot2_enter", disp_data, 32'h2024_1109);
      idle(3, "rot2_hold", 32'h2024_1109);
      pulse(0, 1);
      check("rot2_cancel", disp_data, 32'h12A3_4A30);
      idle(30, "rot2_after", 32'h12A3_4A30);

      sec = 8'h29;
      pulse(1, 0);
      sec = 8'h30;
      pulse(1, 0);
      check("rst_mid_enter", disp_data, 32'h2024_1109);
`else
      sec = 8'h30;
      pulse(1, 0);
      check("norot_sec30", disp_data, 32'h12A3_4A30);
      idle(30, "norot_steady", 32'h12A3_4A30);
      pulse(0, 1);
      check("rst_mid_enter", disp_data, 32'h2024_1109);
`endif

      // Reset in the middle of the date view / hold
      idle(4, "rst_mid_pre", 32'h2024_1109);
      rstn = 1'b0;
      #1;
      check("rst_mid_data", disp_data, 32'hFFFF_FFFF);
      check("rst_mid_upd", {31'b0, disp_upd}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      idle(3, "rst_rel_blank", 32'hFFFF_FFFF);
      pulse(0, 1);
      check("rst_rel_key", disp_data, 32'hFFFF_FFFF);
      sec = 8'h45;
      pulse(1, 0);
      check("rst_rel_time", disp_data, 32'h12A3_4A45);
      check("rst_rel_upd", {31'b0, disp_upd}, 32'd1);
      idle(30, "rst_rel_steady", 32'h12A3_4A45);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
